// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared state encoding and default sizes for reg_write_arbiter
package reg_write_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_masked,
    input  logic [IDW-1:0]  last,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    int j;

    // Scan from the farthest candidate down so the one nearest last+1 is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last) + k) % NREQ;
            if (req_masked[j]) begin
                valid = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter for one shared load-enable register
// Optional feature: define REG_ARB_BACK2BACK_EN to allow one write per cycle.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_en,
    output logic [IDW-1:0]        owner,
    output logic                  busy
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last;
    logic [NREQ-1:0] pick_req;
    logic [IDW-1:0]  pick_last;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic            load_win;
    logic [WIDTH-1:0] wsel;

    always_comb begin
        pick_req  = req;
        pick_last = last;
`ifdef REG_ARB_BACK2BACK_EN
        // While loading, the current owner is excluded and the scan restarts after it.
        if (state == ST_LOAD) begin
            pick_req  = req & ~(NREQ'(1) << owner);
            pick_last = owner;
        end
`endif
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_masked (pick_req),
        .last       (pick_last),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign wsel = wdata[int'(pick_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        reg_en    = 1'b0;
        busy      = 1'b0;
        ack       = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_LOAD;
                    load_win  = 1'b1;
                end
            end
            ST_LOAD: begin
                reg_en     = 1'b1;
                busy       = 1'b1;
                ack[owner] = 1'b1;
`ifdef REG_ARB_BACK2BACK_EN
                if (pick_valid) begin
                    load_win = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Data is captured only at the grant edge; later wdata changes cannot leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_d <= '0;
            owner <= '0;
            last  <= IDW'(NREQ - 1);
        end else begin
            if (state == ST_LOAD) begin
                last <= owner;
            end
            if (load_win) begin
                reg_d <= wsel;
                owner <= pick_idx;
            end
        end
    end

endmodule
